ram_clear_ctrl: RTL and testbench

- Sits directly upstream of the 128 KiB scrambled SPRAM block, between the CPU memory bus and the RAM port.
- Owns the address and data scrambling seed registers and drives them onto the RAM's ram_addr_rand and ram_data_rand inputs.
- After reset, and after every seed reload, it overwrites every RAM word with CLEAR_DATA before the CPU is allowed in, so stale contents are never readable under new seeds.
- In idle it forwards CPU accesses to the RAM, with one-cycle latency.

---
 rtl/ram_clear_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_clear_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_clear_ctrl.sv
// Front end for the scrambled SPRAM: owns the scrambling seeds, wipes the RAM after
// reset and after every seed reload, and forwards CPU accesses while idle.
module ram_clear_ctrl #(
    parameter int unsigned NUM_WORDS  = 32768,
    parameter logic [31:0] CLEAR_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_we,
    input  logic [14:0] seed_addr,
    input  logic [31:0] seed_data,
    output logic        clear_busy,
    input  logic        cpu_cs,
    input  logic [3:0]  cpu_we,
    input  logic [15:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    output logic [31:0] cpu_read_data,
    output logic        cpu_ready,
    output logic [14:0] ram_addr_rand,
    output logic [31:0] ram_data_rand,
    output logic        ram_cs,
    output logic [3:0]  ram_we,
    output logic [15:0] ram_address,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data,
    input  logic        ram_ready
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

    localparam logic [14:0] LAST_WORD = 15'(NUM_WORDS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [14:0] r_clr_cnt;
    logic [14:0] w_clr_cnt_nxt;
    logic        r_pending;
    logic [14:0] r_shadow_addr;
    logic [31:0] r_shadow_data;
    logic [14:0] r_addr_rand;
    logic [31:0] r_data_rand;
    logic        w_cpu_fwd;
    logic        w_seed_load;
    logic        w_seed_commit;

    // A held cs is not re-issued in its own ready cycle, hence the pending gate.
    assign w_cpu_fwd = (r_state == IDLE) & cpu_cs & ~r_pending;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_seed_load   = 1'b0;
        w_seed_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (seed_we) begin
                    w_seed_load = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_seed_commit = 1'b1;
                w_clr_cnt_nxt = '0;
                w_state_nxt   = CLEAR;
            end
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 15'd1;
                if (r_clr_cnt == LAST_WORD) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_comb begin
        ram_cs         = 1'b0;
        ram_we         = '0;
        ram_address    = '0;
        ram_write_data = '0;
        if (!reset) begin
            if (r_state == CLEAR) begin
                ram_cs         = 1'b1;
                ram_we         = '1;
                ram_address    = {1'b0, r_clr_cnt};
                ram_write_data = CLEAR_DATA;
            end else if (w_cpu_fwd) begin
                ram_cs         = 1'b1;
                ram_we         = cpu_we;
                ram_address    = cpu_address;
                ram_write_data = cpu_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= CLEAR;
            r_clr_cnt     <= '0;
            r_pending     <= 1'b0;
            r_shadow_addr <= '0;
            r_shadow_data <= '0;
            r_addr_rand   <= '0;
            r_data_rand   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_pending <= w_cpu_fwd;
            if (w_seed_load) begin
                r_shadow_addr <= seed_addr;
                r_shadow_data <= seed_data;
            end
            // Seeds swap only after DRAIN, so no access straddles two seed sets.
            if (w_seed_commit) begin
                r_addr_rand <= r_shadow_addr;
                r_data_rand <= r_shadow_data;
            end
        end
    end

    // Clear-write readies never reach the CPU since pending is low for them.
    assign cpu_ready     = r_pending & ram_ready & ~reset;
    assign cpu_read_data = ram_read_data;
    assign clear_busy    = (r_state == DRAIN) | (r_state == CLEAR);
    assign ram_addr_rand = r_addr_rand;
    assign ram_data_rand = r_data_rand;

endmodule

// File: tb/tb_ram_clear_ctrl.sv
// Scoreboard bench for ram_clear_ctrl with a behavioural scrambled RAM model.
module tb_ram_clear_ctrl;

    localparam int unsigned NW = 16;
    localparam logic [31:0] CD = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        seed_we = 1'b0;
    logic [14:0] seed_addr = '0;
    logic [31:0] seed_data = '0;
    logic        clear_busy;
    logic        cpu_cs = 1'b0;
    logic [3:0]  cpu_we = '0;
    logic [15:0] cpu_address = '0;
    logic [31:0] cpu_write_data = '0;
    logic [31:0] cpu_read_data;
    logic        cpu_ready;
    logic [14:0] ram_addr_rand;
    logic [31:0] ram_data_rand;
    logic        ram_cs;
    logic [3:0]  ram_we;
    logic [15:0] ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data = '0;
    logic        ram_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } sb_item_t;
    sb_item_t sb_q[$];

    ram_clear_ctrl #(.NUM_WORDS(NW), .CLEAR_DATA(CD)) dut (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_addr(seed_addr),
        .seed_data(seed_data), .clear_busy(clear_busy), .cpu_cs(cpu_cs),
        .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
        .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
        .ram_addr_rand(ram_addr_rand), .ram_data_rand(ram_data_rand),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    // Scrambled SPRAM: physical row = addr ^ addr seed, stored word = data ^ data seed.
    logic [31:0] mem [logic [14:0]];
    always @(posedge clk) begin
        logic [14:0] phys;
        logic [31:0] word;
        ram_ready <= ram_cs;
        if (ram_cs) begin
            phys = ram_address[14:0] ^ ram_addr_rand;
            word = mem.exists(phys) ? mem[phys] : 32'h0;
            if (ram_we != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) word[b*8 +: 8] = ram_write_data[b*8 +: 8] ^ ram_data_rand[b*8 +: 8];
                mem[phys] = word;
            end else begin
                ram_read_data <= word ^ ram_data_rand;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cpu_ready must match a queued access.
    always @(negedge clk) begin
        sb_item_t e;
        if (!reset && cpu_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_cpu_ready: got 1 expected 0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (e.is_read) check("cpu_read_data", cpu_read_data, e.data);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; exp_wait counts negedges up to and including the ready one.
    task automatic cpu_access(input logic [3:0] we, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp,
                              input int exp_wait);
        int n;
        logic got;
        sb_q.push_back('{is_read: (we == 4'h0), data: exp});
        cpu_cs = 1'b1;
        cpu_we = we;
        cpu_address = addr;
        cpu_write_data = wdata;
        n = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (cpu_ready) got = 1'b1;
        end
        check("ready_latency", 32'(n), 32'(exp_wait));
        sync();
        cpu_cs = 1'b0;
        cpu_we = '0;
    endtask

    task automatic check_clear(input logic [14:0] exp_as, input logic [31:0] exp_ds);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_cs && clear_busy) && n < 100);
        check("clear_start_seen", 32'(n < 100), 32'd1);
        for (int unsigned i = 0; i < NW; i++) begin
            check("clear_cs_we", {27'h0, ram_cs, ram_we}, 32'h1f);
            check("clear_addr", {16'h0, ram_address}, 32'(i));
            check("clear_wdata", ram_write_data, CD);
            check("clear_busy_on", {31'h0, clear_busy}, 32'd1);
            check("clear_addr_seed", {17'h0, ram_addr_rand}, {17'h0, exp_as});
            check("clear_data_seed", ram_data_rand, exp_ds);
            @(negedge clk);
        end
        check("clear_busy_off", {31'h0, clear_busy}, 32'd0);
    endtask

    task automatic load_seeds(input logic [14:0] a, input logic [31:0] d);
        seed_we = 1'b1;
        seed_addr = a;
        seed_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: power-on clear with zero seeds, then read back
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ram_cs", {31'h0, ram_cs}, 32'd0);
        check("reset_ram_we", {28'h0, ram_we}, 32'd0);
        check("reset_cpu_ready", {31'h0, cpu_ready}, 32'd0);
        sync();
        reset = 1'b0;
        check_clear(15'h0, 32'h0);
        sync(); cpu_access(4'h0, 16'd3, 32'h0, CD, 2);
        sync(); cpu_access(4'h0, 16'd15, 32'h0, CD, 2);

        // 2: CPU writes/reads, including a partial byte write and back-to-back access
        sync(); cpu_access(4'hf, 16'd5, 32'hDEAD_BEEF, 32'h0, 2);
        sync(); cpu_access(4'h0, 16'd5, 32'h0, 32'hDEAD_BEEF, 2);
        sync(); cpu_access(4'hf, 16'd9, 32'hCAFE_F00D, 32'h0, 2);
        cpu_access(4'b0011, 16'd9, 32'h1234_5678, 32'h0, 2);
        cpu_access(4'h0, 16'd9, 32'h0, 32'hCAFE_5678, 2);

        // 3: seed reload alongside a read; read completes in DRAIN under old seeds
        sync();
        load_seeds(15'h1234, 32'h0BAD_F00D);
        fork
            begin sync(); seed_we = 1'b0; check_clear(15'h1234, 32'h0BAD_F00D); end
            cpu_access(4'h0, 16'd5, 32'h0, 32'hDEAD_BEEF, 2);
        join
        sync(); cpu_access(4'h0, 16'd5, 32'h0, CD, 2);

        // 4: CPU request held across a clear is served on the 2nd IDLE cycle
        sync();
        load_seeds(15'h0042, 32'h1111_2222);
        fork
            begin sync(); seed_we = 1'b0; check_clear(15'h0042, 32'h1111_2222); end
            begin repeat (3) @(posedge clk); #1; cpu_access(4'h0, 16'd7, 32'h0, CD, 17); end
        join

        // 5: reset at clear word 9 restarts the clear from word 0 with zero seeds
        sync();
        load_seeds(15'h0055, 32'h3333_4444);
        sync();
        seed_we = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_cs && clear_busy && ram_address == 16'd8) && n < 100);
        check("word8_seen", 32'(n < 100), 32'd1);
        sync();
        reset = 1'b1;
        @(negedge clk);
        check("midclr_reset_ram_cs", {31'h0, ram_cs}, 32'd0);
        check("midclr_reset_ram_we", {28'h0, ram_we}, 32'd0);
        check("midclr_reset_cpu_ready", {31'h0, cpu_ready}, 32'd0);
        sync();
        sync();
        reset = 1'b0;
        check_clear(15'h0, 32'h0);
        sync(); cpu_access(4'h0, 16'd3, 32'h0, CD, 2);

        // 6: seed_we during CLEAR is ignored and triggers no second clear
        sync();
        load_seeds(15'h0077, 32'h5555_6666);
        fork
            begin sync(); seed_we = 1'b0; check_clear(15'h0077, 32'h5555_6666); end
            begin
                repeat (6) @(posedge clk);
                #1;
                load_seeds(15'h7fff, 32'hFFFF_FFFF);
                sync();
                seed_we = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            check("no_second_clear", {31'h0, clear_busy}, 32'd0);
            check("seed_kept", {17'h0, ram_addr_rand}, 32'h0077);
            check("dseed_kept", ram_data_rand, 32'h5555_6666);
        end
        sync(); cpu_access(4'hf, 16'd5, 32'h0BAD_CAFE, 32'h0, 2);
        sync(); cpu_access(4'h0, 16'd5, 32'h0, 32'h0BAD_CAFE, 2);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
